// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size encodings,
// FSM state type and word geometry.
package lsu_pkg;

  localparam int WORD_BYTES = 4;
  localparam int OFF_W      = $clog2(WORD_BYTES);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit: extracts and extends
// the addressed byte/halfword of a loaded word, and merges store data into
// the addressed lane(s) of an existing word. Any size other than byte or
// half is handled as a full word.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rd_word,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [1:0]            offset,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select, extension and merge; halfword lanes use only offset[1].
  always_comb begin
    byte_lane = rd_word[{offset, 3'b000} +: 8];
    half_lane = rd_word[{offset[1], 4'b0000} +: 16];
    load_data = rd_word;
    merged    = wdata;
    case (size)
      SZ_BYTE: begin
        load_data = {{(DATA_WIDTH-8){~is_unsigned & byte_lane[7]}}, byte_lane};
        merged    = rd_word;
        merged[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{(DATA_WIDTH-16){~is_unsigned & half_lane[15]}}, half_lane};
        merged    = rd_word;
        merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data = rd_word;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between execute and a word-only Data_Memory.
// Loads: IDLE->READ->RESP. Word stores: IDLE->WRITE->RESP.
// Sub-word stores read-modify-write: IDLE->READ->WRITE->RESP.
// Optional feature macro LSU_MISALIGN_TRAP_EN: misaligned half/word and
// reserved-size requests skip memory and answer with rsp_err one cycle later.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_WE,
  output logic [ADDR_WIDTH-1:0] mem_A,
  output logic [DATA_WIDTH-1:0] mem_WD,
  input  logic [DATA_WIDTH-1:0] mem_RD
);

  state_t                state;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [1:0]            off_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;

  logic                  req_err;
  logic [1:0]            size_n;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merged;

`ifdef LSU_MISALIGN_TRAP_EN
  // Flag misaligned half/word and the reserved size for trapping.
  always_comb begin
    size_n = req_size;
    case (req_size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
  end
`else
  // Without trapping the reserved size behaves as a word access.
  always_comb begin
    req_err = 1'b0;
    size_n  = (req_size == 2'b11) ? SZ_WORD : req_size;
  end
`endif

  assign req_ready = (state == IDLE) && !rst;
  assign rsp_err   = err_q;

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .rd_word     (mem_RD),
    .wdata       (wdata_q),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  // Sequencer FSM with registered memory-side and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_WE    <= 1'b0;
      rsp_valid <= 1'b0;
      err_q     <= 1'b0;
      rsp_rdata <= '0;
      mem_A     <= '0;
      mem_WD    <= '0;
    end else begin
      mem_WE    <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= size_n;
            uns_q   <= req_unsigned;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
            mem_A   <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            if (req_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              err_q     <= 1'b1;
              rsp_rdata <= '0;
            end else if (!req_we || size_n != SZ_WORD) begin
              state <= READ;
            end else begin
              state  <= WRITE;
              mem_WE <= 1'b1;
              mem_WD <= req_wdata;
            end
          end
        end
        READ: begin
          if (we_q) begin
            state  <= WRITE;
            mem_WE <= 1'b1;
            mem_WD <= merged;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            err_q     <= 1'b0;
            rsp_rdata <= load_data;
          end
        end
        WRITE: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          err_q     <= 1'b0;
          rsp_rdata <= '0;
        end
        default: begin
          state <= IDLE;
          err_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a word-array memory model drives
// mem_RD, the stimulus computes expected responses/writes from a byte-level
// reference memory, and a negedge monitor pops and compares them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, mem_WE;
  logic [31:0] rsp_rdata, mem_A, mem_WD, mem_RD;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD),
    .mem_RD(mem_RD)
  );

  typedef struct { logic [31:0] rdata; logic err; int cyc; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

  rsp_t        rq[$];
  wr_t         wq[$];
  logic [31:0] env_mem[64];
  logic [31:0] ref_mem[64];
  logic        poke_en = 1'b0;
  int          poke_idx = 0;
  logic [31:0] poke_val = '0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_RD = env_mem[mem_A[7:2]];

  always @(posedge clk) begin
    if (mem_WE) env_mem[mem_A[7:2]] <= mem_WD;
    else if (poke_en) env_mem[poke_idx] <= poke_val;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every response and every memory write must match the scoreboard.
  always @(negedge clk) begin
    rsp_t e;
    wr_t  w;
    if (rsp_valid) begin
      if (rq.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else begin
        e = rq.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        chk("rsp_latency", cyc, e.cyc);
      end
    end
    if (mem_WE) begin
      if (wq.size() == 0) chk("unexpected_write", mem_A, 32'hFFFFFFFF);
      else begin
        w = wq.pop_front();
        chk("mem_A", mem_A, w.addr);
        chk("mem_WD", mem_WD, w.data);
      end
    end
  end

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = idx;
    poke_val = val;
    ref_mem[idx] = val;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", rq.size() + wq.size(), 0);
  endtask

  // Issue one request; the reference model computes response, latency and write.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic use_exp, input logic [31:0] exp_rdata);
    int          n, idx, sh, lat;
    logic [1:0]  sz;
    logic        err;
    logic [31:0] word, lane, mask, nw;
    rsp_t        r;
    wr_t         w;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    sz  = size;
    err = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    err = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
`else
    if (size == 2'b11) sz = 2'b10;
`endif
    idx  = int'(addr[7:2]);
    word = ref_mem[idx];
    r.err = err;
    r.rdata = 32'd0;
    sh   = (sz == 2'b00) ? 8 * int'(addr[1:0]) : 16 * int'(addr[1]);
    mask = (sz == 2'b00) ? (32'hFF << sh) : (sz == 2'b01) ? (32'hFFFF << sh) : 32'hFFFFFFFF;
    if (sz == 2'b10) sh = 0;
    if (err) lat = 1;
    else if (!we) begin
      lat  = 2;
      lane = (word & mask) >> sh;
      r.rdata = lane;
      if (!uns && sz == 2'b00 && lane >= 128)   r.rdata = 32'(int'(lane) - 256);
      if (!uns && sz == 2'b01 && lane >= 32768) r.rdata = 32'(int'(lane) - 65536);
    end else begin
      lat = (sz == 2'b10) ? 2 : 3;
      nw  = (word & ~mask) | ((wdata << sh) & mask);
      ref_mem[idx] = nw;
      w.addr = addr & 32'hFFFFFFFC;
      w.data = nw;
      wq.push_back(w);
    end
    if (use_exp) r.rdata = exp_rdata;
    r.cyc = cyc + lat;
    rq.push_back(r);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_addr = $urandom; req_wdata = $urandom; req_unsigned = 1'($urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 64; i++) poke(i, $urandom);
    @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_mem_WE", {31'd0, mem_WE}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_A", mem_A, 32'd0);
    chk("rst_mem_WD", mem_WD, 32'd0);
    rst = 1'b0;
    #1 chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Word store then word load at 0x28.
    issue(1'b1, 2'b10, 1'b0, 32'h28, 32'hDEADBEEF, 1'b0, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h28, 32'h0, 1'b1, 32'hDEADBEEF);
    drain();

    // Sub-word loads with sign and zero extension.
    poke(4, 32'h80FF7F01);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b1, 32'hFFFFFF80);
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b1, 32'h0000007F);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1, 32'hFFFF80FF);
    drain();

    // Byte store read-modify-write; upper wdata bits must be ignored.
    poke(4, 32'h11223344);
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h123456AB, 1'b0, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h11AB3344);

    // Misaligned word store: trapped or written at 0x28 depending on build.
    issue(1'b1, 2'b10, 1'b0, 32'h2A, 32'hCAFEF00D, 1'b0, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h28, 32'h0, 1'b0, 32'd0);
    drain();

    // Reset during the READ cycle of a half store: nothing may follow.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_mem_WE", {31'd0, mem_WE}, 32'd0);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    #1 chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("midrst_mem_word", env_mem[8], ref_mem[8]);

    // Randomized mix of loads and stores.
    for (int t = 0; t < 300; t++) begin
      issue(1'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 255),
            $urandom, 1'b0, 32'd0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    for (int i = 0; i < 64; i++) chk("mem_final", env_mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
